// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane extraction with sign/zero extension for loads,
// read-modify-write narrowing for sub-word stores. Optional ack watchdog: ACK_TIMEOUT_EN.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              SignExtend,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              Fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic [1:0]        dbgState
);

    // Memory handshake: a request is open while dmem_req=1; it completes on the
    // first rising edge where dmem_ack=1, and ack is ignored while dmem_req=0.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, nextState;

    if (TIMEOUT < 1) begin : gTimeoutCheck
        $error("mem_access_unit: TIMEOUT must be at least 1");
    end

    logic cmd, illegal, legal, timeoutHit;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    logic [31:0] loadExt, mergeWord;

    assign cmd     = MemRead | MemWrite;
    assign illegal = (MemRead & MemWrite) || (Size == 2'b11) ||
                     (Size == 2'b01 && Address[0]) ||
                     (Size == 2'b10 && Address[1:0] != 2'b00);
    assign legal   = cmd & ~illegal;

`ifdef ACK_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] waitCnt;
    logic            timedOutQ;

    assign timeoutHit = (state == RD || state == WR) && !dmem_ack &&
                        (waitCnt == CntW'(TIMEOUT - 1));

    // Counter restarts on every state change so RD and WR each get a full budget.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            waitCnt   <= '0;
            timedOutQ <= 1'b0;
        end else begin
            timedOutQ <= timeoutHit;
            if (state != nextState)
                waitCnt <= '0;
            else if (state == RD || state == WR)
                waitCnt <= waitCnt + 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (legal) begin
                    if (MemRead)
                        nextState = RD;
                    else if (Size == 2'b10)
                        nextState = WR;
                    else
                        nextState = RD;
                end
            end
            RD: begin
                if (dmem_ack)
                    nextState = MemWrite ? WR : DONE;
                else if (timeoutHit)
                    nextState = DONE;
            end
            WR: begin
                if (dmem_ack || timeoutHit)
                    nextState = DONE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        Stall = Rst_n && ((state == IDLE && legal) || state == RD || state == WR);
`ifdef ACK_TIMEOUT_EN
        Fault = Rst_n && ((state == IDLE && cmd && illegal) || (state == DONE && timedOutQ));
`else
        Fault = Rst_n && (state == IDLE && cmd && illegal);
`endif
        dbgState = state;
    end

    // Little-endian lane select and merge; Address is held stable during the access.
    always_comb begin
        case (Address[1:0])
            2'd0:    rdByte = dmem_rdata[7:0];
            2'd1:    rdByte = dmem_rdata[15:8];
            2'd2:    rdByte = dmem_rdata[23:16];
            default: rdByte = dmem_rdata[31:24];
        endcase
        rdHalf = Address[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (Size)
            2'b00:   loadExt = {{24{SignExtend & rdByte[7]}}, rdByte};
            2'b01:   loadExt = {{16{SignExtend & rdHalf[15]}}, rdHalf};
            default: loadExt = dmem_rdata;
        endcase

        mergeWord = dmem_rdata;
        if (Size == 2'b00) begin
            case (Address[1:0])
                2'd0:    mergeWord[7:0]   = WriteData[7:0];
                2'd1:    mergeWord[15:8]  = WriteData[7:0];
                2'd2:    mergeWord[23:16] = WriteData[7:0];
                default: mergeWord[31:24] = WriteData[7:0];
            endcase
        end else if (Address[1]) begin
            mergeWord[31:16] = WriteData[15:0];
        end else begin
            mergeWord[15:0] = WriteData[15:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ReadData   <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            dmem_req <= (nextState == RD) || (nextState == WR);
            dmem_we  <= (nextState == WR);
            if (state == IDLE && legal) begin
                dmem_addr <= {Address[ADDR_W-1:2], 2'b00};
                if (MemWrite && Size == 2'b10)
                    dmem_wdata <= WriteData;
            end
            if (state == RD && dmem_ack) begin
                if (MemWrite)
                    dmem_wdata <= mergeWord;
                else
                    ReadData <= loadExt;
            end else if (state == RD && timeoutHit && MemRead) begin
                ReadData <= '0;
            end
        end
    end

endmodule
